// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared types and address-field helpers for the direct-mapped
//               write-through data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

  // Cache controller states: serving requests, or streaming a line in.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  // Helpers work on a wide address so one set of functions fits any width.
  localparam int c_ADDR_MAX = 64;
  typedef logic [c_ADDR_MAX-1:0] addr_t;

  // Byte offset inside a line: word select plus the two byte-in-word bits.
  function automatic int offset_bits(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int addr_width, input int sets, input int line_words);
    return addr_width - index_bits(sets) - offset_bits(line_words);
  endfunction

  function automatic addr_t get_word_sel(input addr_t a, input int line_words);
    return (a >> 2) & addr_t'(line_words - 1);
  endfunction

  function automatic addr_t get_index(input addr_t a, input int sets, input int line_words);
    return (a >> offset_bits(line_words)) & addr_t'(sets - 1);
  endfunction

  function automatic addr_t get_tag(input addr_t a, input int sets, input int line_words);
    return a >> (offset_bits(line_words) + index_bits(sets));
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_direct_mapped_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_direct_mapped_if
// Description : CPU-side and memory-side signal bundle of the data cache.
//               slave  = the cache itself
//               master = its environment (CPU load/store path plus memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_direct_mapped_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  // CPU side
  logic                     req;
  logic                     WE;
  logic                     addr_mode;
  logic [ADDRESS_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0]    WD;
  logic [DATA_WIDTH-1:0]    RD;
  logic                     stall;
  // Memory side
  logic [ADDRESS_WIDTH-1:0] mem_A;
  logic                     mem_WE;
  logic                     mem_addr_mode;
  logic [DATA_WIDTH-1:0]    mem_WD;
  logic [DATA_WIDTH-1:0]    mem_RD;
  // Performance counters
  logic [31:0]              hit_count;
  logic [31:0]              miss_count;

  modport slave (
    input  req, WE, addr_mode, A, WD, mem_RD,
    output RD, stall, mem_A, mem_WE, mem_addr_mode, mem_WD, hit_count, miss_count
  );

  modport master (
    output req, WE, addr_mode, A, WD, mem_RD,
    input  RD, stall, mem_A, mem_WE, mem_addr_mode, mem_WD, hit_count, miss_count
  );
endinterface
`default_nettype wire

// File: rtl/dcache_line_store.sv
`default_nettype none
// ============================================================================
// Module      : dcache_line_store
// Description : Valid/tag/data arrays of the direct-mapped cache.
//               Combinational read by index, synchronous word/byte writes,
//               valid set and invalidate, asynchronous clear of valid bits.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int WS_BITS    = 2,
  parameter int TAG_BITS   = 24,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  // Read port
  input  wire logic [INDEX_BITS-1:0] i_rd_index,
  input  wire logic [WS_BITS-1:0]    i_rd_word_sel,
  output logic                       o_rd_valid,
  output logic [TAG_BITS-1:0]        o_rd_tag,
  output logic [DATA_WIDTH-1:0]      o_rd_word,
  // Write port
  input  wire logic                  i_word_we,
  input  wire logic                  i_byte_we,
  input  wire logic [INDEX_BITS-1:0] i_wr_index,
  input  wire logic [WS_BITS-1:0]    i_wr_word_sel,
  input  wire logic [1:0]            i_wr_byte_sel,
  input  wire logic [DATA_WIDTH-1:0] i_wr_data,
  // Line validation (uses i_wr_index) and invalidation
  input  wire logic                  i_set_valid,
  input  wire logic [TAG_BITS-1:0]   i_set_tag,
  input  wire logic                  i_inv_en,
  input  wire logic [INDEX_BITS-1:0] i_inv_index_a,
  input  wire logic [INDEX_BITS-1:0] i_inv_index_b
);

  localparam int c_SETS  = 1 << INDEX_BITS;
  localparam int c_WORDS = 1 << WS_BITS;
  localparam int c_LANES = DATA_WIDTH / 8;

  logic [c_SETS-1:0]     r_valid;
  logic [TAG_BITS-1:0]   r_tag  [c_SETS];
  logic [DATA_WIDTH-1:0] r_data [c_SETS][c_WORDS];

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_word  = r_data[i_rd_index][i_rd_word_sel];

  // Valid bits: async clear; invalidate first so a same-edge set would win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      if (i_inv_en) begin
        r_valid[i_inv_index_a] <= 1'b0;
        r_valid[i_inv_index_b] <= 1'b0;
      end
      if (i_set_valid) begin
        r_valid[i_wr_index] <= 1'b1;
      end
    end
  end

  // Tag captured when a refill completes.
  always_ff @(posedge clk) begin
    if (i_set_valid) begin
      r_tag[i_wr_index] <= i_set_tag;
    end
  end

  // Data words: full-word write (refill or word store) or single byte lane.
  always_ff @(posedge clk) begin
    if (i_word_we) begin
      r_data[i_wr_index][i_wr_word_sel] <= i_wr_data;
    end else if (i_byte_we) begin
      for (int b = 0; b < c_LANES; b++) begin
        if (i_wr_byte_sel == 2'(b)) begin
          r_data[i_wr_index][i_wr_word_sel][b*8 +: 8] <= i_wr_data[7:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module      : dcache_direct_mapped
// Description : Direct-mapped, write-through, no-write-allocate data cache.
//               Load misses stall while a line is refilled one word per
//               cycle; stores always write through in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_direct_mapped
  import dcache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SETS          = 16,
  parameter int LINE_WORDS    = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  dcache_direct_mapped_if.slave bus
);

  localparam int c_INDEX_BITS = index_bits(SETS);
  localparam int c_TAG_BITS   = tag_bits(ADDRESS_WIDTH, SETS, LINE_WORDS);
  localparam int c_WS_BITS    = $clog2(LINE_WORDS);
  localparam logic [c_WS_BITS-1:0] c_LAST_WORD = c_WS_BITS'(LINE_WORDS - 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [c_TAG_BITS-1:0]   r_tag;
  logic [c_INDEX_BITS-1:0] r_index;
  logic [c_WS_BITS-1:0]    r_cnt;
  logic [31:0]             r_hit_count;
  logic [31:0]             r_miss_count;

  // Address field split of the CPU address and of A+3 (last byte of a
  // misaligned word, which may live in the next line).
  addr_t w_a_ext, w_a3_ext;
  addr_t w_tag_full, w_index_full, w_ws_full, w_index3_full;
  logic [c_TAG_BITS-1:0]   w_tag;
  logic [c_INDEX_BITS-1:0] w_index;
  logic [c_INDEX_BITS-1:0] w_index3;
  logic [c_WS_BITS-1:0]    w_ws;
  logic                    w_unused_fields;

  assign w_a_ext       = addr_t'(bus.A);
  assign w_a3_ext      = addr_t'(bus.A + ADDRESS_WIDTH'(3));
  assign w_tag_full    = get_tag(w_a_ext, SETS, LINE_WORDS);
  assign w_index_full  = get_index(w_a_ext, SETS, LINE_WORDS);
  assign w_ws_full     = get_word_sel(w_a_ext, LINE_WORDS);
  assign w_index3_full = get_index(w_a3_ext, SETS, LINE_WORDS);
  assign w_tag         = w_tag_full[c_TAG_BITS-1:0];
  assign w_index       = w_index_full[c_INDEX_BITS-1:0];
  assign w_ws          = w_ws_full[c_WS_BITS-1:0];
  assign w_index3      = w_index3_full[c_INDEX_BITS-1:0];
  assign w_unused_fields = ^{w_tag_full[c_ADDR_MAX-1:c_TAG_BITS],
                             w_index_full[c_ADDR_MAX-1:c_INDEX_BITS],
                             w_ws_full[c_ADDR_MAX-1:c_WS_BITS],
                             w_index3_full[c_ADDR_MAX-1:c_INDEX_BITS]};

  // Line store connections
  logic                    w_line_valid;
  logic [c_TAG_BITS-1:0]   w_line_tag;
  logic [DATA_WIDTH-1:0]   w_line_word;
  logic                    w_word_we, w_byte_we, w_set_valid, w_inv_en;
  logic [c_INDEX_BITS-1:0] w_wr_index;
  logic [c_WS_BITS-1:0]    w_wr_word_sel;
  logic [DATA_WIDTH-1:0]   w_wr_data;

  dcache_line_store #(
    .INDEX_BITS (c_INDEX_BITS),
    .WS_BITS    (c_WS_BITS),
    .TAG_BITS   (c_TAG_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_line_store (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_rd_index    (w_index),
    .i_rd_word_sel (w_ws),
    .o_rd_valid    (w_line_valid),
    .o_rd_tag      (w_line_tag),
    .o_rd_word     (w_line_word),
    .i_word_we     (w_word_we),
    .i_byte_we     (w_byte_we),
    .i_wr_index    (w_wr_index),
    .i_wr_word_sel (w_wr_word_sel),
    .i_wr_byte_sel (bus.A[1:0]),
    .i_wr_data     (w_wr_data),
    .i_set_valid   (w_set_valid),
    .i_set_tag     (r_tag),
    .i_inv_en      (w_inv_en),
    .i_inv_index_a (w_index),
    .i_inv_index_b (w_index3)
  );

  logic       w_hit, w_aligned, w_load, w_store;
  logic [7:0] w_line_byte;
  logic       w_hit_inc, w_miss_inc;

  assign w_hit     = w_line_valid && (w_line_tag == w_tag);
  assign w_aligned = bus.addr_mode || (bus.A[1:0] == 2'b00);
  assign w_load    = bus.req && !bus.WE;
  assign w_store   = bus.req && bus.WE;

  // Little-endian byte lane pick for byte-load hits.
  always_comb begin
    w_line_byte = w_line_word[7:0];
    case (bus.A[1:0])
      2'd1:    w_line_byte = w_line_word[15:8];
      2'd2:    w_line_byte = w_line_word[23:16];
      2'd3:    w_line_byte = w_line_word[31:24];
      default: w_line_byte = w_line_word[7:0];
    endcase
  end

  // Next state, CPU/memory outputs and line-store write controls.
  always_comb begin
    w_state_next      = r_state;
    bus.stall         = 1'b0;
    bus.RD            = '0;
    bus.mem_A         = bus.A;
    bus.mem_WE        = 1'b0;
    bus.mem_addr_mode = bus.addr_mode;
    bus.mem_WD        = bus.WD;
    w_word_we         = 1'b0;
    w_byte_we         = 1'b0;
    w_wr_index        = w_index;
    w_wr_word_sel     = w_ws;
    w_wr_data         = bus.WD;
    w_set_valid       = 1'b0;
    w_inv_en          = 1'b0;
    w_hit_inc         = 1'b0;
    w_miss_inc        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_store) begin
          bus.mem_WE = 1'b1;
          if (!w_aligned) begin
            w_inv_en = 1'b1;
          end else if (w_hit) begin
            w_word_we = !bus.addr_mode;
            w_byte_we = bus.addr_mode;
          end
        end else if (w_load) begin
          if (!w_aligned) begin
            bus.RD = bus.mem_RD;
          end else if (w_hit) begin
            bus.RD    = bus.addr_mode ? {{(DATA_WIDTH-8){1'b0}}, w_line_byte} : w_line_word;
            w_hit_inc = 1'b1;
          end else begin
            bus.stall    = 1'b1;
            w_miss_inc   = 1'b1;
            w_state_next = REFILL;
          end
        end
      end
      REFILL: begin
        bus.stall         = 1'b1;
        bus.mem_A         = {r_tag, r_index, r_cnt, 2'b00};
        bus.mem_addr_mode = 1'b0;
        w_word_we         = 1'b1;
        w_wr_index        = r_index;
        w_wr_word_sel     = r_cnt;
        w_wr_data         = bus.mem_RD;
        if (r_cnt == c_LAST_WORD) begin
          w_set_valid  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    // Outputs stay quiet for the whole time reset is held.
    if (!rst_n) begin
      bus.stall  = 1'b0;
      bus.mem_WE = 1'b0;
      bus.RD     = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Refill target capture and word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag   <= '0;
      r_index <= '0;
      r_cnt   <= '0;
    end else if (w_miss_inc) begin
      r_tag   <= w_tag;
      r_index <= w_index;
      r_cnt   <= '0;
    end else if (r_state == REFILL) begin
      r_cnt <= r_cnt + c_WS_BITS'(1);
    end
  end

  // Hit/miss performance counters (wrap naturally).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit_inc) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss_inc) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_dcache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_direct_mapped
// Description : Directed, table-driven bench for dcache_direct_mapped with a
//               byte-addressed behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_direct_mapped;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_direct_mapped_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dcache_direct_mapped #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .SETS          (16),
    .LINE_WORDS    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- behavioural memory ----------------
  logic [7:0]  mem [0:262143];
  logic [17:0] mem_idx;
  logic        loaded = 1'b0;

  always_comb begin
    mem_idx = bus.mem_A[17:0];
    if (bus.mem_addr_mode)
      bus.mem_RD = {24'h0, mem[mem_idx]};
    else
      bus.mem_RD = {mem[mem_idx + 18'd3], mem[mem_idx + 18'd2],
                    mem[mem_idx + 18'd1], mem[mem_idx]};
  end

  task automatic put_word(input logic [17:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) mem[a + 18'(i)] <= d[i*8 +: 8];
  endtask

  always @(posedge clk) begin
    if (!loaded) begin
      put_word(18'h10000, 32'h11111111);
      put_word(18'h10004, 32'h22222222);
      put_word(18'h10008, 32'h33333333);
      put_word(18'h1000C, 32'h44444444);
      put_word(18'h20000, 32'h55555555);
      put_word(18'h20004, 32'h66666666);
      put_word(18'h20008, 32'h77777777);
      put_word(18'h2000C, 32'h88888888);
      loaded <= 1'b1;
    end else if (bus.mem_WE) begin
      if (bus.mem_addr_mode) mem[bus.mem_A[17:0]] <= bus.mem_WD[7:0];
      else put_word(bus.mem_A[17:0], bus.mem_WD);
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic mode,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req = req; bus.WE = we; bus.addr_mode = mode; bus.A = a; bus.WD = wd;
  endtask

  task automatic chk_counts(input string nm, input logic [31:0] hits, input logic [31:0] misses);
    chk({nm, " hit_count"}, bus.hit_count, hits);
    chk({nm, " miss_count"}, bus.miss_count, misses);
  endtask

  // Word load that must miss: 1 IDLE stall + 4 refill cycles, then a hit.
  task automatic load_miss(input string nm, input logic [31:0] a, input logic [31:0] exp_rd);
    logic [31:0] base;
    base = {a[31:4], 4'h0};
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, a, 32'h0);
    @(negedge clk);
    chk({nm, " miss stall"}, {31'b0, bus.stall}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("%s refill%0d stall", nm, k), {31'b0, bus.stall}, 32'd1);
      chk($sformatf("%s refill%0d mem_A", nm, k), bus.mem_A, base + 32'(4 * k));
      chk($sformatf("%s refill%0d mem_WE", nm, k), {31'b0, bus.mem_WE}, 32'd0);
    end
    @(negedge clk);
    chk({nm, " done stall"}, {31'b0, bus.stall}, 32'd0);
    chk({nm, " done RD"}, bus.RD, exp_rd);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, a, 32'h0);
  endtask

  typedef struct packed {
    logic        req;
    logic        we;
    logic        mode;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_stall;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_mem_we;
  } vec_t;

  function automatic vec_t mk(input logic req, input logic we, input logic mode,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic chk_rd, input logic [31:0] exp_rd,
                              input logic exp_mem_we);
    vec_t v;
    v.req = req; v.we = we; v.mode = mode; v.a = a; v.wd = wd;
    v.exp_stall = 1'b0; v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_mem_we = exp_mem_we;
    return v;
  endfunction

  vec_t vt [0:8];

  initial begin
    // Single-cycle accesses after the first refill of line 0x10000.
    vt[0] = mk(1, 0, 0, 32'h0001000C, 32'h0,        1, 32'h44444444, 0); // word hit
    vt[1] = mk(1, 0, 1, 32'h00010009, 32'h0,        1, 32'h00000033, 0); // byte hit
    vt[2] = mk(1, 1, 1, 32'h00010005, 32'h000000AB, 0, 32'h0,        1); // byte store hit
    vt[3] = mk(1, 0, 0, 32'h00010004, 32'h0,        1, 32'h2222AB22, 0); // sees store
    vt[4] = mk(1, 1, 0, 32'h00020000, 32'hCAFEF00D, 0, 32'h0,        1); // store miss
    vt[5] = mk(1, 0, 0, 32'h00010000, 32'h0,        1, 32'h11111111, 0); // no allocate
    vt[6] = mk(1, 0, 0, 32'h00010001, 32'h0,        1, 32'h22111111, 0); // misaligned load
    vt[7] = mk(0, 0, 1, 32'h00012345, 32'h0,        1, 32'h0,        0); // idle
    vt[8] = mk(1, 1, 0, 32'h0001000E, 32'hDEADBEEF, 0, 32'h0,        1); // misaligned store

    // ---- reset state, with a load and then a store held on the bus ----
    drive(1'b1, 1'b0, 1'b0, 32'h00010004, 32'h0);
    @(negedge clk);
    chk("rst stall", {31'b0, bus.stall}, 32'd0);
    chk("rst mem_WE", {31'b0, bus.mem_WE}, 32'd0);
    chk("rst RD", bus.RD, 32'd0);
    chk_counts("rst", 32'd0, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h00010004, 32'h12345678);
    #1;
    chk("rst store mem_WE", {31'b0, bus.mem_WE}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    rst_n = 1'b1;

    // ---- cold load miss ----
    load_miss("cold", 32'h00010004, 32'h22222222);
    chk_counts("cold", 32'd1, 32'd1);

    // ---- table of single-cycle accesses ----
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      drive(vt[i].req, vt[i].we, vt[i].mode, vt[i].a, vt[i].wd);
      @(negedge clk);
      chk($sformatf("vec%0d stall", i), {31'b0, bus.stall}, {31'b0, vt[i].exp_stall});
      chk($sformatf("vec%0d mem_WE", i), {31'b0, bus.mem_WE}, {31'b0, vt[i].exp_mem_we});
      chk($sformatf("vec%0d mem_A", i), bus.mem_A, vt[i].a);
      chk($sformatf("vec%0d mem_mode", i), {31'b0, bus.mem_addr_mode}, {31'b0, vt[i].mode});
      if (vt[i].exp_mem_we) chk($sformatf("vec%0d mem_WD", i), bus.mem_WD, vt[i].wd);
      if (vt[i].chk_rd) chk($sformatf("vec%0d RD", i), bus.RD, vt[i].exp_rd);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_counts("table", 32'd5, 32'd1);

    // ---- misaligned store invalidated line 0: refetch picks up new bytes ----
    load_miss("inval", 32'h0001000C, 32'hBEEF4444);
    chk_counts("inval", 32'd6, 32'd2);

    // ---- conflict eviction and re-miss ----
    load_miss("conflict", 32'h00020000, 32'hCAFEF00D);
    chk_counts("conflict", 32'd7, 32'd3);
    load_miss("remiss", 32'h00010000, 32'h11111111);
    chk_counts("remiss", 32'd8, 32'd4);

    // ---- reset in refill cycle 2 ----
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h00020004, 32'h0);
    @(negedge clk);
    chk("mid miss stall", {31'b0, bus.stall}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    chk("mid refill2 mem_A", bus.mem_A, 32'h00020008);
    rst_n = 1'b0;
    #1;
    chk("mid rst stall", {31'b0, bus.stall}, 32'd0);
    chk("mid rst mem_WE", {31'b0, bus.mem_WE}, 32'd0);
    chk("mid rst RD", bus.RD, 32'd0);
    chk_counts("mid rst", 32'd0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    load_miss("post_rst", 32'h00010004, 32'h2222AB22);
    chk_counts("post_rst", 32'd1, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Overall time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
